// File: rtl/grostl_inv_sub_bytes_iter.sv
// Inverse AES SubBytes over a 64-byte Groestl state, eight bytes per beat across eight beats.
// Latency 8 cycles from accept to dout_valid (9 with GROSTL_INV_SB_PIPE_EN); result held in DONE until dout_ready.
module grostl_inv_sub_bytes_iter (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:63][7:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [0:63][7:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       beat_q, beat_d;
    logic [0:63][7:0] src_q, src_d;
    logic [0:63][7:0] res_q, res_d;
    logic [0:7][7:0]  sb_out;

`ifdef GROSTL_INV_SB_PIPE_EN
    logic [0:7][7:0]  pipe_q, pipe_d;
    logic             pipe_vld_q, pipe_vld_d;
    logic [2:0]       pipe_beat_q, pipe_beat_d;
`endif

    // Eight shared lookups, steered by the beat counter.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sb_out[i] = INV_SBOX[src_q[{beat_q, 3'(i)}]];
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        src_d   = src_q;
        res_d   = res_q;
`ifdef GROSTL_INV_SB_PIPE_EN
        pipe_d      = pipe_q;
        pipe_vld_d  = 1'b0;
        pipe_beat_d = pipe_beat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    src_d   = din;
                    beat_d  = 3'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef GROSTL_INV_SB_PIPE_EN
                // Counter parks on 7 while the last lookup drains from the pipe stage.
                beat_d      = (beat_q == 3'd7) ? beat_q : beat_q + 3'd1;
                pipe_d      = sb_out;
                pipe_vld_d  = 1'b1;
                pipe_beat_d = beat_q;
                if (pipe_vld_q) begin
                    for (int i = 0; i < 8; i++) begin
                        res_d[{pipe_beat_q, 3'(i)}] = pipe_q[i];
                    end
                    if (pipe_beat_q == 3'd7) begin
                        state_d    = S_DONE;
                        beat_d     = 3'd0;
                        pipe_vld_d = 1'b0;
                    end
                end
`else
                for (int i = 0; i < 8; i++) begin
                    res_d[{beat_q, 3'(i)}] = sb_out[i];
                end
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (dout_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= 3'd0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

`ifdef GROSTL_INV_SB_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q      <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_beat_q <= 3'd0;
        end else begin
            pipe_q      <= pipe_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_beat_q <= pipe_beat_d;
        end
    end
`endif

    assign din_ready  = (state_q == S_IDLE);
    assign dout_valid = (state_q == S_DONE);
    assign dout       = res_q;

endmodule

// File: tb/tb_grostl_inv_sub_bytes_iter.sv
// Directed bench for grostl_inv_sub_bytes_iter; honours GROSTL_INV_SB_PIPE_EN for expected latency.
module tb_grostl_inv_sub_bytes_iter;

`ifdef GROSTL_INV_SB_PIPE_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [0:63][7:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [0:63][7:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] fwd_tab [0:255];

    always #5 clk = ~clk;

    grostl_inv_sub_bytes_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward AES S-box from first principles: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        repeat (254) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic send(input logic [0:63][7:0] st);
        int n;
        n = 0;
        while (!din_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: din_ready=%b required 1", din_ready);
        end
        din       = st;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!dout_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_timeout: dout_valid=%b required 1 after %0d cycles", dout_valid, cyc);
        end
    endtask

    task automatic test_reset;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== '0) begin
            errors++;
            $display("FAIL reset_state: din_ready=%b dout_valid=%b dout=%h required 1 0 0",
                     din_ready, dout_valid, dout);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== '0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: din_ready=%b dout_valid=%b dout=%h required 1 0 0",
                         c, din_ready, dout_valid, dout);
            end
        end
    endtask

    task automatic test_known_vector;
        logic [0:63][7:0] st, exp;
        int cyc;
        for (int i = 0; i < 64; i++) begin
            st[i]  = 8'h63;
            exp[i] = 8'h00;
        end
        st[0]  = 8'h7c; exp[0]  = 8'h01;
        st[63] = 8'h16; exp[63] = 8'hff;
        send(st);
        wait_valid(cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL known_latency: got %0d cycles required %0d", cyc, LAT);
        end
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL known_vector: got %h required %h", dout, exp);
        end
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL known_consume: dout_valid=%b din_ready=%b required 0 1", dout_valid, din_ready);
        end
    endtask

    task automatic test_backpressure;
        logic [0:63][7:0] st, exp;
        int cyc;
        for (int i = 0; i < 64; i++) begin
            st[i]  = (i < 32) ? 8'hed : 8'h00;
            exp[i] = (i < 32) ? 8'h53 : 8'h52;
        end
        dout_ready = 1'b1;
        send(st);
        // Disturb din during RUN; dout_ready is high here too and must have no effect.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 64; i++) din[i] = 8'($urandom_range(255));
            din_valid = 1'b1;
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
        dout_ready = 1'b0;
        wait_valid(cyc);
        for (int c = 0; c < 15; c++) begin
            checks++;
            if (dout !== exp || din_ready !== 1'b0 || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure cycle %0d: dout=%h din_ready=%b dout_valid=%b required %h 0 1",
                         c, dout, din_ready, dout_valid, exp);
            end
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: din_ready=%b dout_valid=%b required 1 0", din_ready, dout_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [0:63][7:0] st_a, st_b, exp_a, exp_b, res1, res2;
        int t1, t2, n_res, falls, edge_n;
        logic prev_rdy;
        for (int i = 0; i < 64; i++) begin
            st_a[i] = 8'h00; exp_a[i] = 8'h52;
            st_b[i] = 8'hed; exp_b[i] = 8'h53;
        end
        res1 = '0; res2 = '0; t1 = 0; t2 = 0;
        n_res = 0; falls = 0; edge_n = 0;
        din        = st_a;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        prev_rdy   = din_ready;
        while (n_res < 2 && edge_n < 60) begin
            @(posedge clk); #1;
            edge_n++;
            if (prev_rdy && !din_ready) begin
                falls++;
                if (falls == 1) din = st_b;
                else din_valid = 1'b0;
            end
            prev_rdy = din_ready;
            if (dout_valid) begin
                n_res++;
                if (n_res == 1) begin t1 = edge_n; res1 = dout; end
                else begin t2 = edge_n; res2 = dout; end
            end
        end
        din_valid = 1'b0;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        checks++;
        if (n_res !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 2", n_res);
        end
        checks++;
        if (res1 !== exp_a) begin
            errors++;
            $display("FAIL b2b_first: got %h required %h", res1, exp_a);
        end
        checks++;
        if (res2 !== exp_b) begin
            errors++;
            $display("FAIL b2b_second: got %h required %h", res2, exp_b);
        end
        // First result is consumed on the edge after it appears; count from there to the next result.
        checks++;
        if (t2 - (t1 + 1) !== LAT + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d", t2 - (t1 + 1), LAT + 1);
        end
    endtask

    task automatic test_reset_mid;
        logic [0:63][7:0] st, exp;
        int cyc;
        for (int i = 0; i < 64; i++) begin
            st[i]  = 8'h63;
            exp[i] = 8'h00;
        end
        st[0] = 8'h7c;
        send(st);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || dout !== '0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: dout_valid=%b dout=%h din_ready=%b required 0 0 1",
                     dout_valid, dout, din_ready);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: din_ready=%b dout_valid=%b required 1 0", din_ready, dout_valid);
        end
        for (int i = 0; i < 64; i++) begin
            exp[i] = 8'(i * 3 + 1);
            st[i]  = fwd_tab[exp[i]];
        end
        send(st);
        wait_valid(cyc);
        checks++;
        if (cyc !== LAT || dout !== exp) begin
            errors++;
            $display("FAIL reset_mid_fresh: latency %0d dout=%h required %0d %h", cyc, dout, LAT, exp);
        end
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
    endtask

    task automatic test_round_trip;
        logic [0:63][7:0] orig, st;
        int cyc;
        dout_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 64; i++) begin
                orig[i] = 8'($urandom_range(255));
                st[i]   = fwd_tab[orig[i]];
            end
            send(st);
            wait_valid(cyc);
            checks++;
            if (dout !== orig) begin
                errors++;
                $display("FAIL round_trip %0d: got %h required %h", n, dout, orig);
            end
        end
        @(posedge clk); #1;
        dout_ready = 1'b0;
    endtask

    initial begin
        for (int x = 0; x < 256; x++) fwd_tab[x] = fwd_sbox(8'(x));
        test_reset();
        test_known_vector();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
